// File: rtl/jesd204_ramp_checker_pkg.sv
// Shared lane state encoding and ramp field-width helpers for the JESD204 RX ramp checker.
package jesd204_ramp_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_LOCKED = 2'd2
    } lane_state_e;

    localparam int MISS_W = 4;

    function automatic int idx_width(input int dpw);
        return (dpw <= 2) ? 1 : ((dpw <= 4) ? 2 : 3);
    endfunction

    function automatic int cnt_width(input int dpw);
        return 8 - idx_width(dpw);
    endfunction

endpackage

// File: rtl/jesd204_rx_ramp_checker_lane.sv
// One lane of the ramp checker: lock FSM, expected counter, miss run, sticky flag and error count.
// The error counter exists only when JESD204_RAMP_CHECKER_ERR_CNT_EN is defined.
module jesd204_rx_ramp_checker_lane
    import jesd204_ramp_checker_pkg::*;
#(
    parameter int DATA_PATH_WIDTH     = 4,
    parameter int SCR_SKIP_OCTETS     = 2,
    parameter int LOCK_LOSS_THRESHOLD = 4,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                         clk_i,
    input  logic                         resetn_i,
    input  logic                         sync_i,
    input  logic                         rx_valid_i,
    input  logic [DATA_PATH_WIDTH*8-1:0] rx_data_i,
    input  logic                         lane_disable_i,
    input  logic                         clr_stats_i,
    output logic                         lane_locked_o,
    output logic                         lane_err_sticky_o,
    output logic [ERR_CNT_WIDTH-1:0]     lane_err_cnt_o
);
    localparam int IDX_W  = idx_width(DATA_PATH_WIDTH);
    localparam int CNT_W  = cnt_width(DATA_PATH_WIDTH);
    localparam int SKIP_N = (SCR_SKIP_OCTETS < DATA_PATH_WIDTH) ? SCR_SKIP_OCTETS : DATA_PATH_WIDTH;
    localparam logic [MISS_W-1:0] THRESH_M1 = MISS_W'(LOCK_LOSS_THRESHOLD - 1);

    lane_state_e               state_q, state_d;
    logic [CNT_W-1:0]          exp_q, exp_d;
    logic [MISS_W-1:0]         miss_q, miss_d;
    logic                      skip_q, skip_d;
    logic                      sticky_q, sticky_d;

    logic [DATA_PATH_WIDTH-1:0] octet_use;
    logic [DATA_PATH_WIDTH-1:0] idx_ok;
    logic [DATA_PATH_WIDTH-1:0] cnt_ok;
    logic [DATA_PATH_WIDTH-1:0] full_ok;
    logic [CNT_W-1:0]           seed_cnt;
    logic                       seek_pass;
    logic                       locked_miss;
    logic                       err_inc;

    // The top octet is never skipped when any octet is usable, so it seeds the lock value.
    always_comb begin
        seed_cnt = rx_data_i[DATA_PATH_WIDTH*8-1 -: CNT_W];
        for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
            octet_use[k] = !(skip_q && (k < SKIP_N));
            idx_ok[k]    = (rx_data_i[k*8 +: IDX_W] == IDX_W'(k));
            cnt_ok[k]    = (rx_data_i[k*8+IDX_W +: CNT_W] == seed_cnt);
            full_ok[k]   = (rx_data_i[k*8 +: 8] == {exp_q, IDX_W'(k)});
        end
        seek_pass   = (&(~octet_use | (idx_ok & cnt_ok))) && (|octet_use);
        locked_miss = |(octet_use & ~full_ok);
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        miss_d  = miss_q;
        skip_d  = skip_q;
        err_inc = 1'b0;
        if (!sync_i || lane_disable_i) begin
            state_d = ST_IDLE;
            skip_d  = 1'b1;
            miss_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SEEK;
                    skip_d  = 1'b1;
                end
                ST_SEEK: begin
                    if (rx_valid_i) begin
                        skip_d = 1'b0;
                        miss_d = '0;
                        if (seek_pass) begin
                            state_d = ST_LOCKED;
                            exp_d   = seed_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (rx_valid_i) begin
                        skip_d = 1'b0;
                        exp_d  = exp_q + 1'b1;
                        if (locked_miss) begin
                            err_inc = 1'b1;
                            if (miss_q >= THRESH_M1) begin
                                state_d = ST_SEEK;
                                miss_d  = '0;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end else begin
                            miss_d = '0;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A clear pulse beats a same-cycle error.
    always_comb begin
        sticky_d = sticky_q;
        if (clr_stats_i) begin
            sticky_d = 1'b0;
        end else if (err_inc) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            exp_q    <= '0;
            miss_q   <= '0;
            skip_q   <= 1'b1;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            miss_q   <= miss_d;
            skip_q   <= skip_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef JESD204_RAMP_CHECKER_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_stats_i) begin
            err_cnt_d = '0;
        end else if (err_inc && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign lane_err_cnt_o = err_cnt_q;
`else
    assign lane_err_cnt_o = '0;
`endif

    assign lane_locked_o     = (state_q == ST_LOCKED);
    assign lane_err_sticky_o = sticky_q;

endmodule

// File: rtl/jesd204_rx_ramp_checker.sv
// JESD204 RX ramp checker top: NUM_LANES independent lane checkers plus the all-locked summary.
// Per-lane error counters are built only when JESD204_RAMP_CHECKER_ERR_CNT_EN is defined.
module jesd204_rx_ramp_checker
    import jesd204_ramp_checker_pkg::*;
#(
    parameter int NUM_LANES           = 4,
    parameter int DATA_PATH_WIDTH     = 4,
    parameter int SCR_SKIP_OCTETS     = 2,
    parameter int LOCK_LOSS_THRESHOLD = 4,
    parameter int ERR_CNT_WIDTH       = 16
) (
    input  logic                                   clk_i,
    input  logic                                   resetn_i,
    input  logic                                   sync_i,
    input  logic                                   rx_valid_i,
    input  logic [NUM_LANES*DATA_PATH_WIDTH*8-1:0] rx_data_i,
    input  logic [NUM_LANES-1:0]                   lanes_disable_i,
    input  logic                                   clr_stats_i,
    output logic [NUM_LANES-1:0]                   lane_locked_o,
    output logic [NUM_LANES-1:0]                   lane_err_sticky_o,
    output logic [NUM_LANES*ERR_CNT_WIDTH-1:0]     lane_err_cnt_o,
    output logic                                   all_locked_o
);
    localparam int LANE_W = DATA_PATH_WIDTH * 8;

    logic all_locked_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        jesd204_rx_ramp_checker_lane #(
            .DATA_PATH_WIDTH     (DATA_PATH_WIDTH),
            .SCR_SKIP_OCTETS     (SCR_SKIP_OCTETS),
            .LOCK_LOSS_THRESHOLD (LOCK_LOSS_THRESHOLD),
            .ERR_CNT_WIDTH       (ERR_CNT_WIDTH)
        ) u_lane (
            .clk_i             (clk_i),
            .resetn_i          (resetn_i),
            .sync_i            (sync_i),
            .rx_valid_i        (rx_valid_i),
            .rx_data_i         (rx_data_i[l*LANE_W +: LANE_W]),
            .lane_disable_i    (lanes_disable_i[l]),
            .clr_stats_i       (clr_stats_i),
            .lane_locked_o     (lane_locked_o[l]),
            .lane_err_sticky_o (lane_err_sticky_o[l]),
            .lane_err_cnt_o    (lane_err_cnt_o[l*ERR_CNT_WIDTH +: ERR_CNT_WIDTH])
        );
    end

    // Disabled lanes count as locked, so an all-disabled link reports locked.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            all_locked_q <= 1'b0;
        end else begin
            all_locked_q <= &(lane_locked_o | lanes_disable_i);
        end
    end

    assign all_locked_o = all_locked_q;

endmodule

// File: tb/tb_jesd204_rx_ramp_checker.sv
// Self-checking bench for jesd204_rx_ramp_checker with a behavioural lane reference model.
module tb_jesd204_rx_ramp_checker;
    localparam int NL   = 4;
    localparam int DPW  = 4;
    localparam int SKIP = 2;
    localparam int THR  = 4;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;
    localparam int CMOD = 256 / DPW;

    logic                  clk = 1'b0;
    logic                  resetn = 1'b0;
    logic                  sync = 1'b0;
    logic                  rx_valid = 1'b0;
    logic                  clr_stats = 1'b0;
    logic [NL*DPW*8-1:0]   rx_data = '0;
    logic [NL-1:0]         lanes_disable = '0;
    logic [NL-1:0]         lane_locked;
    logic [NL-1:0]         lane_err_sticky;
    logic [NL*CW-1:0]      lane_err_cnt;
    logic                  all_locked;

    always #5 clk = ~clk;

    jesd204_rx_ramp_checker #(
        .NUM_LANES           (NL),
        .DATA_PATH_WIDTH     (DPW),
        .SCR_SKIP_OCTETS     (SKIP),
        .LOCK_LOSS_THRESHOLD (THR),
        .ERR_CNT_WIDTH       (CW)
    ) dut (
        .clk_i             (clk),
        .resetn_i          (resetn),
        .sync_i            (sync),
        .rx_valid_i        (rx_valid),
        .rx_data_i         (rx_data),
        .lanes_disable_i   (lanes_disable),
        .clr_stats_i       (clr_stats),
        .lane_locked_o     (lane_locked),
        .lane_err_sticky_o (lane_err_sticky),
        .lane_err_cnt_o    (lane_err_cnt),
        .all_locked_o      (all_locked)
    );

    typedef struct {
        logic [NL-1:0]    locked;
        logic [NL-1:0]    sticky;
        logic [NL*CW-1:0] cnt;
        logic             all;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: a lane is inactive (link down/disabled), searching, or locked.
    bit m_active[NL];
    bit m_locked[NL];
    bit m_fresh[NL];
    int m_exp[NL];
    int m_miss[NL];
    int m_errs[NL];
    bit m_sticky[NL];
    bit m_all;

    int            tx_cnt;
    bit            tx_first;
    bit            g_rst;
    bit            g_sync;
    logic [NL-1:0] g_dis;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NL; l++) begin
            m_active[l] = 0; m_locked[l] = 0; m_fresh[l] = 1;
            m_exp[l] = 0; m_miss[l] = 0; m_errs[l] = 0; m_sticky[l] = 0;
        end
        m_all = 0;
    endtask

    task automatic lane_step(input int l);
        int  first;
        int  c;
        int  oct[DPW];
        bit  ok;
        bit  bad;
        bit  inc;
        inc = 0;
        if (!sync || lanes_disable[l]) begin
            m_active[l] = 0; m_locked[l] = 0; m_fresh[l] = 1; m_miss[l] = 0;
        end else if (!m_active[l]) begin
            m_active[l] = 1; m_fresh[l] = 1;
        end else if (rx_valid) begin
            first = m_fresh[l] ? SKIP : 0;
            for (int k = 0; k < DPW; k++) oct[k] = int'(rx_data[(l*DPW+k)*8 +: 8]);
            if (!m_locked[l]) begin
                ok = 1;
                c  = oct[first] / DPW;
                for (int k = first; k < DPW; k++)
                    if ((oct[k] % DPW) != k || (oct[k] / DPW) != c) ok = 0;
                if (ok) begin
                    m_locked[l] = 1; m_exp[l] = (c + 1) % CMOD; m_miss[l] = 0;
                end
            end else begin
                bad = 0;
                for (int k = first; k < DPW; k++)
                    if (oct[k] != m_exp[l] * DPW + k) bad = 1;
                m_exp[l] = (m_exp[l] + 1) % CMOD;
                if (bad) begin
                    inc = 1;
                    m_miss[l]++;
                    if (m_miss[l] >= THR) begin
                        m_locked[l] = 0; m_miss[l] = 0;
                    end
                end else begin
                    m_miss[l] = 0;
                end
            end
            m_fresh[l] = 0;
        end
        if (inc) begin
`ifdef JESD204_RAMP_CHECKER_ERR_CNT_EN
            if (m_errs[l] < CMAX) m_errs[l]++;
`endif
            m_sticky[l] = 1;
        end
        if (clr_stats) begin
            m_errs[l] = 0; m_sticky[l] = 0;
        end
    endtask

    task automatic model_clock();
        bit all_n;
        all_n = 1;
        for (int l = 0; l < NL; l++) all_n &= (m_locked[l] || lanes_disable[l]);
        if (!resetn) begin
            model_reset();
        end else begin
            m_all = all_n;
            for (int l = 0; l < NL; l++) lane_step(l);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        for (int l = 0; l < NL; l++) begin
            e.locked[l] = m_locked[l];
            e.sticky[l] = m_sticky[l];
            e.cnt[l*CW +: CW] = CW'(m_errs[l]);
        end
        e.all = m_all;
        sb_q.push_back(e);
    endtask

    task automatic beat(input bit v, input logic [NL-1:0] bad, input bit clr);
        logic [7:0] oct;
        int         pos;
        @(negedge clk);
        resetn        = !g_rst;
        sync          = g_sync;
        lanes_disable = g_dis;
        clr_stats     = clr;
        rx_valid      = v;
        for (int l = 0; l < NL; l++) begin
            for (int j = 0; j < DPW; j++) begin
                oct = 8'(tx_cnt * DPW + j);
                if (!v || (tx_first && j < SKIP)) oct = 8'($urandom);
                rx_data[(l*DPW+j)*8 +: 8] = oct;
            end
            if (v && bad[l]) begin
                pos = (l * DPW + int'($urandom % DPW)) * 8 + int'($urandom % 8);
                rx_data[pos] = ~rx_data[pos];
            end
        end
        if (v) begin
            tx_cnt   = (tx_cnt + 1) % CMOD;
            tx_first = 0;
        end
        model_clock();
        if (!resetn) begin
            #1;
            check("rst_locked", 64'(lane_locked), 64'd0);
            check("rst_sticky", 64'(lane_err_sticky), 64'd0);
            check("rst_cnt", 64'(lane_err_cnt), 64'd0);
            check("rst_all", 64'(all_locked), 64'd0);
        end
        push_expected();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("lane_locked", 64'(lane_locked), 64'(e.locked));
                check("lane_err_sticky", 64'(lane_err_sticky), 64'(e.sticky));
                check("lane_err_cnt", 64'(lane_err_cnt), 64'(e.cnt));
                check("all_locked", 64'(all_locked), 64'(e.all));
            end
        end
    end

    initial begin : stimulus
        bit            v;
        logic [NL-1:0] bad;
        bit            clr;
        model_reset();
        tx_cnt = 0; tx_first = 1;
        g_rst = 1; g_sync = 0; g_dis = '0;
        repeat (3) beat(0, '0, 0);
        g_rst = 0;
        repeat (3) beat(0, '0, 0);

        g_sync = 1; tx_cnt = 0; tx_first = 1;
        repeat (2) beat(0, '0, 0);
        repeat (1000) beat(1, '0, 0);

        repeat (150) begin
            beat(1, '0, 0); beat(0, '0, 0); beat(0, '0, 0);
        end

        while (tx_cnt != 'h15) beat(1, '0, 0);
        beat(1, 4'b0100, 0);
        repeat (10) beat(1, '0, 0);

        repeat (4) beat(1, 4'b0001, 0);
        repeat (5) beat(1, '0, 0);

        repeat (15) begin
            repeat (3) beat(1, 4'b1000, 0);
            beat(1, '0, 0);
        end
        beat(1, 4'b1000, 1);
        repeat (5) beat(1, '0, 0);

        g_rst = 1;
        repeat (2) beat(1, '0, 0);
        g_rst = 0; tx_first = 1;
        repeat (10) beat(1, '0, 0);
        beat(1, 4'b0010, 0);
        g_sync = 0;
        repeat (4) beat(1, '0, 0);
        g_sync = 1; tx_first = 1; tx_cnt = int'($urandom % CMOD);
        repeat (2) beat(0, '0, 0);
        repeat (20) beat(1, '0, 0);

        g_dis = 4'b0010;
        repeat (10) beat(1, '0, 0);
        repeat (3) beat(1, 4'b0010, 0);
        g_dis = '0;
        repeat (10) beat(1, '0, 0);
        g_dis = 4'hF;
        repeat (3) beat(1, '0, 0);
        g_dis = '0;
        repeat (8) beat(1, '0, 0);

        repeat (1500) begin
            v   = ($urandom % 4) != 0;
            bad = (($urandom % 16) == 0) ? NL'($urandom) : '0;
            clr = ($urandom % 64) == 0;
            if (($urandom % 200) == 0) g_dis[$urandom % NL] ^= 1'b1;
            if (($urandom % 300) == 0) begin
                g_sync = !g_sync;
                if (g_sync) tx_first = 1;
            end
            beat(v, bad, clr);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jesd204_rx_ramp_checker.md
# jesd204_rx_ramp_checker

Synthesizable receive-side checker for the JESD204 ramp pattern: each octet is `{beat_counter, octet_index}`, counter incrementing once per beat. Sits on the `rx_data`/`rx_valid` output of `jesd204_rx` and is the receiving end of the transmit ramp generator. It locks per lane to the incoming ramp, compares every valid beat against the expected value, and reports lock state and error statistics for on-hardware link bring-up.

## Interface
Parameters:
- `NUM_LANES`, 4, lanes checked independently
- `DATA_PATH_WIDTH`, 4, octets per lane per beat; 2, 4 or 8
- `SCR_SKIP_OCTETS`, 2, low octets of lane beat 0 after link-up excluded from compare (scrambler seed)
- `LOCK_LOSS_THRESHOLD`, 4, consecutive mismatching beats that drop lock; 1..15
- `ERR_CNT_WIDTH`, 16, per-lane error counter width

Ports:
- `clk` in 1, device clock
- `resetn` in 1, asynchronous, active-low reset
- `sync` in 1, link sync; low = link not established
- `rx_valid` in 1, beat qualifier
- `rx_data` in NUM_LANES*DATA_PATH_WIDTH*8, lane-major receive data
- `lanes_disable` in NUM_LANES, disabled lanes held in IDLE, excluded from `all_locked`
- `clr_stats` in 1, one-cycle pulse clearing error counters and sticky flags
- `lane_locked` out NUM_LANES, lane in LOCKED
- `lane_err_sticky` out NUM_LANES, set on any mismatch while LOCKED
- `lane_err_cnt` out NUM_LANES*ERR_CNT_WIDTH, mismatching beats while LOCKED
- `all_locked` out 1, all enabled lanes locked

## Operation
- IDX_W = log2(DATA_PATH_WIDTH); CNT_W = 8-IDX_W. Octet k of a beat = `{cnt[CNT_W-1:0], k[IDX_W-1:0]}`; all octets of a beat share `cnt`.
- Per-lane FSM: IDLE, SEEK, LOCKED.
- IDLE: entered on reset, `sync`=0 or lane disabled. Leaves to SEEK when `sync`=1 and lane enabled. Arms the scrambler-skip flag.
- SEEK: on `rx_valid`, compare only index fields of non-skipped octets, and require equal `cnt` across them. Pass: expected = cnt+1 (mod 2^CNT_W), go LOCKED. Fail: stay. Skip flag clears after first valid beat.
- LOCKED: on `rx_valid`, compare all non-skipped octets fully to expected. Expected increments every valid beat regardless of result (no reseed). Mismatch: increment miss run; run reaching LOCK_LOSS_THRESHOLD → SEEK. Match clears miss run.
- `rx_valid`=0: no state change, expected holds.
- `sync` falling in any state → IDLE next cycle; counters/sticky retained.
- Error counter saturates at all-ones. `clr_stats` and an increment in the same cycle: clear wins (counter = 0, sticky = 0).
- Lane disable mid-operation → IDLE; its stats frozen.

## Timing
- All outputs registered; status reflects beat N on cycle N+1.
- Lock: first passing SEEK beat at cycle T → `lane_locked` high at T+1.
- Lock loss: threshold-th consecutive miss at T → `lane_locked` low at T+1.
- `all_locked` = registered AND of `lane_locked | lanes_disable`; one extra cycle after `lane_locked`. With all lanes disabled, `all_locked`=1.
- Reset: `lane_locked`=0, `lane_err_sticky`=0, `lane_err_cnt`=0, `all_locked`=0, FSMs IDLE.

## Configuration
- `JESD204_RAMP_CHECKER_ERR_CNT_EN` defined: per-lane saturating counters implemented as above.
- Undefined: no counter registers; `lane_err_cnt` ties to 0. Sticky flags, lock FSM and `all_locked` are unchanged.

## Structure
- Package `jesd204_ramp_checker_pkg`: state encoding (IDLE=2'd0, SEEK=2'd1, LOCKED=2'd2), IDX_W/CNT_W derivation function.
- Sub-module `jesd204_rx_ramp_checker_lane`: one lane's FSM, expected counter, compare, miss run, counter/sticky. Top instantiates NUM_LANES copies and the `all_locked` reduction.

## Test plan
- Clean ramp, DPW=4, `sync` rises, data from cnt=0, skip octets garbage → `lane_locked`=1 one cycle after first valid beat, `all_locked` one cycle later, `lane_err_cnt`=0 after 1000 beats.
- Single corrupted octet on lane 2 at cnt=0x15 → `lane_err_cnt[2]`=1, sticky[2]=1, lane 2 stays locked, other lanes 0.
- Four consecutive bad beats on lane 0 (threshold 4) → lane 0 drops lock after 4th, re-locks on next clean beat, count=4.
- `rx_valid` gapped 1-of-3 with ramp advancing only on valid → no errors; counter wrap 0x3F→0x00 → no errors.
- Counter at 0xFFFF plus further error → holds 0xFFFF; `clr_stats` coincident with error → 0.
- `resetn` low mid-LOCKED → all outputs 0 immediately; `sync` low → lock drops next cycle, counts kept; lane 1 disabled → `all_locked` ignores it.
